// File: rtl/moving_average_inverse_pkg.sv
// Shared types and elaboration helpers for the moving-average inverse.
package moving_average_inverse_pkg;

  typedef enum logic [0:0] {
    HIST_CLEAR = 1'b0,
    HIST_READY = 1'b1
  } hist_state_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ma_inv_history.sv
// History RAM (1R/1W, synchronous read) with a post-reset clear sweep.
module ma_inv_history
  import moving_average_inverse_pkg::*;
#(
  parameter int unsigned WINDOW_LEN = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned IW         = 38
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        rd_addr_i,
  output logic signed [IW-1:0] rd_data_o,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic signed [IW-1:0] wr_data_i,
  output logic                 ready_o
);

  hist_state_e          state_q, state_d;
  logic [AW-1:0]        clr_cnt_q, clr_cnt_d;
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic signed [IW-1:0] mem_wdata;
  logic signed [IW-1:0] mem_q [WINDOW_LEN];
  logic signed [IW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= HIST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // While clearing, the sweep owns the write port; afterwards the pipeline does.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    if (state_q == HIST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(WINDOW_LEN - 1)) begin
        state_d = HIST_READY;
      end
    end else begin
      mem_we = wr_en_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
  assign ready_o   = (state_q == HIST_READY);

endmodule

// File: rtl/moving_average_inverse.sv
// Reconstructs x[n] = N*(y[n]-y[n-1]) + x[n-N] from a boxcar-averaged stream.
module moving_average_inverse
  import moving_average_inverse_pkg::*;
#(
  parameter int unsigned DIN_WIDTH  = 32,
  parameter int unsigned DIN_POINT  = 31,
  parameter int unsigned WINDOW_LEN = 16,
  parameter int unsigned DOUT_WIDTH = 32,
  parameter int unsigned DOUT_POINT = 27
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic                         dout_ovf
);

  localparam int unsigned LOG2_N = $clog2(WINDOW_LEN);
  localparam int unsigned DW     = DIN_WIDTH + 1;
  localparam int unsigned IW     = DIN_WIDTH + LOG2_N + 2;
  localparam int unsigned SHR    = (DIN_POINT > DOUT_POINT) ? (DIN_POINT - DOUT_POINT) : 0;
  localparam int unsigned SHL    = (DOUT_POINT > DIN_POINT) ? (DOUT_POINT - DIN_POINT) : 0;
  localparam int unsigned SW     = max_u(IW + SHL, DOUT_WIDTH + 1);

  localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(DOUT_WIDTH - 1){1'b1}}});
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  if (!is_pow2(WINDOW_LEN) || (WINDOW_LEN < 4)) begin : g_bad_window
    $fatal(1, "WINDOW_LEN must be a power of two and at least 4");
  end

  logic signed [DIN_WIDTH-1:0]  y_prev_q, y_prev_d;
  logic signed [DW-1:0]         diff_q, diff_d;
  logic                         s1_valid_q, s1_valid_d;
  logic [LOG2_N-1:0]            wr_ptr_q, wr_ptr_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;
  logic                         dout_ovf_q, dout_ovf_d;

  logic                         hist_ready;
  logic [LOG2_N-1:0]            rd_addr;
  logic signed [IW-1:0]         x_old;
  logic signed [IW-1:0]         acc;
  logic signed [SW-1:0]         acc_ext;
  logic signed [SW-1:0]         aligned;
  logic                         accept;

  // A sample in stage 2 still owns wr_ptr_q, so the next sample reads one slot ahead.
  assign accept  = din_valid && hist_ready;
  assign rd_addr = s1_valid_q ? (wr_ptr_q + LOG2_N'(1)) : wr_ptr_q;

  ma_inv_history #(
    .WINDOW_LEN (WINDOW_LEN),
    .AW         (LOG2_N),
    .IW         (IW)
  ) u_history (
    .clk        (clk),
    .rst        (rst),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (x_old),
    .wr_en_i    (s1_valid_q),
    .wr_addr_i  (wr_ptr_q),
    .wr_data_i  (acc),
    .ready_o    (hist_ready)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      y_prev_q     <= '0;
      diff_q       <= '0;
      s1_valid_q   <= 1'b0;
      wr_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_ovf_q   <= 1'b0;
    end else begin
      y_prev_q     <= y_prev_d;
      diff_q       <= diff_d;
      s1_valid_q   <= s1_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_ovf_q   <= dout_ovf_d;
    end
  end

  // Accumulate at full width, then realign (floor) and saturate for the output only.
  always_comb begin
    y_prev_d     = y_prev_q;
    diff_d       = diff_q;
    s1_valid_d   = accept;
    wr_ptr_d     = wr_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = s1_valid_q;
    dout_ovf_d   = dout_ovf_q;

    acc     = (IW'(diff_q) <<< LOG2_N) + x_old;
    acc_ext = SW'(acc);
    aligned = (acc_ext <<< SHL) >>> SHR;

    if (accept) begin
      diff_d   = DW'(din) - DW'(y_prev_q);
      y_prev_d = din;
    end

    if (s1_valid_q) begin
      wr_ptr_d = wr_ptr_q + LOG2_N'(1);
      if (aligned > SAT_MAX) begin
        dout_d     = DOUT_WIDTH'(SAT_MAX);
        dout_ovf_d = 1'b1;
      end else if (aligned < SAT_MIN) begin
        dout_d     = DOUT_WIDTH'(SAT_MIN);
        dout_ovf_d = 1'b1;
      end else begin
        dout_d     = DOUT_WIDTH'(aligned);
        dout_ovf_d = 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_ovf   = dout_ovf_q;

endmodule

// File: tb/tb_moving_average_inverse.sv
// Scoreboard bench: directed vectors plus a modelled-averager loopback.
module tb_moving_average_inverse;

  typedef struct {
    int d;
    bit ovf;
    int cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] din_a, din_b;
  logic               dv_in_a, dv_in_b;
  logic signed [15:0] dout_a;
  logic signed [11:0] dout_b;
  logic               dv_a, dv_b, ovf_a, ovf_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   xh[4];

  int step_y[6] = '{1, 2, 3, 4, 4, 4};
  int imp_y[8]  = '{2, 2, 2, 2, 0, 0, 0, 0};
  int imp_x[8]  = '{8, 0, 0, 0, 0, 0, 0, 0};
  int sat_y[7]  = '{0, 8000, 0, 0, 0, -7999, 1};
  int sat_x[7]  = '{0, 2047, -2048, 0, 0, 4, 0};
  bit sat_o[7]  = '{0, 1, 1, 0, 0, 0, 0};

  moving_average_inverse #(
    .DIN_WIDTH(16), .DIN_POINT(2), .WINDOW_LEN(4), .DOUT_WIDTH(16), .DOUT_POINT(0)
  ) u_dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(dv_in_a),
    .dout(dout_a), .dout_valid(dv_a), .dout_ovf(ovf_a)
  );

  moving_average_inverse #(
    .DIN_WIDTH(16), .DIN_POINT(2), .WINDOW_LEN(4), .DOUT_WIDTH(12), .DOUT_POINT(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(dv_in_b),
    .dout(dout_b), .dout_valid(dv_b), .dout_ovf(ovf_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every presented output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dv_a === 1'b1) begin
      if (q_a.size() == 0) check("a_spurious_valid", 1, 0);
      else begin
        ea = q_a.pop_front();
        check("a_dout", int'(dout_a), ea.d);
        check("a_ovf", int'(ovf_a), int'(ea.ovf));
        check("a_cycle", cyc, ea.cyc);
      end
    end
    if (dv_b === 1'b1) begin
      if (q_b.size() == 0) check("b_spurious_valid", 1, 0);
      else begin
        eb = q_b.pop_front();
        check("b_dout", int'(dout_b), eb.d);
        check("b_ovf", int'(ovf_b), int'(eb.ovf));
        check("b_cycle", cyc, eb.cyc);
      end
    end
  end

  task automatic send_a(input int raw, input int xe);
    @(negedge clk);
    din_a   = 16'(raw);
    dv_in_a = 1'b1;
    q_a.push_back('{d: xe, ovf: 1'b0, cyc: cyc + 2});
  endtask

  task automatic send_b(input int raw, input int xe, input bit ov);
    @(negedge clk);
    din_b   = 16'(raw);
    dv_in_b = 1'b1;
    q_b.push_back('{d: xe, ovf: ov, cyc: cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dv_in_a = 1'b0;
      dv_in_b = 1'b0;
    end
  endtask

  // One-cycle reset; in-flight samples are dropped, then four clear cycles follow.
  task automatic do_reset(input bit junk);
    @(negedge clk);
    rst     = 1'b0;
    dv_in_a = 1'b0;
    dv_in_b = 1'b0;
    while (q_a.size() > 0 && q_a[$].cyc >= cyc + 1) void'(q_a.pop_back());
    while (q_b.size() > 0 && q_b[$].cyc >= cyc + 1) void'(q_b.pop_back());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst     = 1'b1;
      dv_in_a = junk;
      din_a   = 16'($urandom);
    end
  endtask

  initial begin
    int x, sum;
    rst = 1'b0; dv_in_a = 1'b0; dv_in_b = 1'b0; din_a = '0; din_b = '0;
    repeat (2) @(negedge clk);
    check("reset_dout", int'(dout_a), 0);
    check("reset_valid", int'(dv_a), 0);
    check("reset_ovf", int'(ovf_a), 0);

    do_reset(1'b0);
    foreach (step_y[i]) send_a(step_y[i] * 4, 4);
    idle(4);

    do_reset(1'b0);
    foreach (imp_y[i]) send_a(imp_y[i] * 4, imp_x[i]);
    idle(4);

    do_reset(1'b0);
    foreach (step_y[i]) begin
      send_a(step_y[i] * 4, 4);
      idle(2);
    end
    idle(4);

    do_reset(1'b0);
    foreach (sat_y[i]) send_b(sat_y[i] * 4, sat_x[i], sat_o[i]);
    idle(4);

    do_reset(1'b0);
    for (int i = 1; i <= 3; i++) send_a(i * 4, 4);
    do_reset(1'b1);
    for (int i = 1; i <= 4; i++) send_a(i * 4, 4);
    idle(4);

    do_reset(1'b0);
    xh = '{0, 0, 0, 0};
    for (int n = 0; n < 1000; n++) begin
      x = int'($urandom_range(16383)) - 8192;
      xh[3] = xh[2]; xh[2] = xh[1]; xh[1] = xh[0]; xh[0] = x;
      sum = xh[0] + xh[1] + xh[2] + xh[3];
      send_a(sum, x);
      if ($urandom_range(3) == 0) idle(1);
    end
    idle(4);

    for (int i = 0; i < 20 && (q_a.size() + q_b.size()) > 0; i++) @(negedge clk);
    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
